dcache_sram_nway: RTL and testbench

Parametrised N-way set-associative data-cache storage array: tag, valid and dirty bits, line data, and true-LRU replacement state per set. Sits under the dcache controller: combinational lookup, clocked updates. Adds a flush engine that walks the array and hands each dirty line to the controller over a valid/ready write-back port, with optional invalidation.

---
 rtl/dcache_sram_nway.sv | 140 ++++++++++++++
 tb/tb_dcache_sram_nway.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_sram_nway.sv
// dcache_sram_nway: N-way set-associative tag/data/true-LRU array with a dirty-line flush engine.
module dcache_sram_nway #(
  parameter int SETS   = 16,
  parameter int WAYS   = 2,
  parameter int TAG_W  = 23,
  parameter int LINE_W = 256,
  localparam int IDX_W = $clog2(SETS),
  localparam int WAY_W = $clog2(WAYS),
  localparam int PTR_W = IDX_W + WAY_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic [1:0]        op_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              dirty_i,
  output logic              ready_o,
  output logic              hit_o,
  output logic [WAY_W-1:0]  hit_way_o,
  output logic [LINE_W-1:0] data_o,
  output logic [WAY_W-1:0]  victim_way_o,
  output logic              victim_valid_o,
  output logic              victim_dirty_o,
  output logic [TAG_W-1:0]  victim_tag_o,
  input  logic              flush_i,
  input  logic              flush_inv_i,
  output logic              busy_o,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [IDX_W-1:0]  wb_idx_o,
  output logic [TAG_W-1:0]  wb_tag_o,
  output logic [LINE_W-1:0] wb_data_o,
  output logic              flush_done_o
);
  typedef enum logic [1:0] {IDLE, SCAN, WB, DONE} state_t;
  state_t              r_state;
  logic [PTR_W-1:0]    r_ptr;
  logic                r_inv;
  logic                r_valid [SETS][WAYS];
  logic                r_dirty [SETS][WAYS];
  logic [TAG_W-1:0]    r_tag   [SETS][WAYS];
  logic [LINE_W-1:0]   r_data  [SETS][WAYS];
  logic [WAY_W-1:0]    r_age   [SETS][WAYS];
  logic                w_hit, w_any_inv, w_act, w_fill, w_wr, w_last, w_pdirty;
  logic [WAY_W-1:0]    w_hit_way, w_vinv, w_vlru, w_vw, w_uw, w_uage, w_pw;
  logic [IDX_W-1:0]    w_ps;
  always_comb begin
    w_hit = 1'b0;
    w_hit_way = '0;
    w_any_inv = 1'b0;
    w_vinv = '0;
    w_vlru = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (r_valid[idx_i][w] && r_tag[idx_i][w] == tag_i) begin
        w_hit = 1'b1;
        w_hit_way = WAY_W'(w);
      end
      if (!r_valid[idx_i][w]) begin
        w_any_inv = 1'b1;
        w_vinv = WAY_W'(w);
      end
      if (r_age[idx_i][w] == WAY_W'(WAYS-1)) w_vlru = WAY_W'(w);
    end
  end
  assign w_vw           = w_any_inv ? w_vinv : w_vlru;
  assign w_act          = req_i & ready_o;
  assign w_fill         = op_i == 2'b10;
  assign w_wr           = w_fill | (op_i == 2'b01 & w_hit);
  assign w_uw           = w_hit ? w_hit_way : w_vw;
  assign w_uage         = r_age[idx_i][w_uw];
  assign busy_o         = r_state != IDLE;
  assign ready_o        = ~busy_o;
  assign hit_o          = w_act & w_hit;
  assign hit_way_o      = hit_o ? w_hit_way : '0;
  assign data_o         = w_act ? r_data[idx_i][w_uw] : '0;
  assign victim_way_o   = w_vw;
  assign victim_valid_o = r_valid[idx_i][w_vw];
  assign victim_dirty_o = r_dirty[idx_i][w_vw];
  assign victim_tag_o   = r_tag[idx_i][w_vw];
  assign w_ps           = r_ptr[PTR_W-1:WAY_W];
  assign w_pw           = r_ptr[WAY_W-1:0];
  assign w_last         = &r_ptr;
  assign w_pdirty       = r_valid[w_ps][w_pw] & r_dirty[w_ps][w_pw];
  assign wb_valid_o     = r_state == WB;
  assign wb_idx_o       = w_ps;
  assign wb_tag_o       = r_tag[w_ps][w_pw];
  assign wb_data_o      = r_data[w_ps][w_pw];
  assign flush_done_o   = r_state == DONE;
  // Accesses only run in IDLE and flush writes only outside IDLE, so the two never collide.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_inv <= 1'b0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) begin
          r_valid[s][w] <= 1'b0;
          r_dirty[s][w] <= 1'b0;
          r_tag[s][w] <= '0;
          r_data[s][w] <= '0;
          r_age[s][w] <= WAY_W'(w);
        end
    end else begin
      if (w_act) begin
        if (w_wr) r_data[idx_i][w_uw] <= data_i;
        if (w_fill) begin
          r_tag[idx_i][w_uw] <= tag_i;
          r_valid[idx_i][w_uw] <= 1'b1;
          r_dirty[idx_i][w_uw] <= dirty_i;
        end else if (w_wr) r_dirty[idx_i][w_uw] <= 1'b1;
        if (w_fill || w_hit)
          for (int v = 0; v < WAYS; v++)
            if (WAY_W'(v) == w_uw) r_age[idx_i][v] <= '0;
            else if (r_age[idx_i][v] < w_uage) r_age[idx_i][v] <= r_age[idx_i][v] + WAY_W'(1);
      end
      case (r_state)
        IDLE: if (flush_i) begin
          r_state <= SCAN;
          r_ptr <= '0;
          r_inv <= flush_inv_i;
        end
        SCAN: if (w_pdirty) r_state <= WB;
        else begin
          if (r_inv) r_valid[w_ps][w_pw] <= 1'b0;
          r_ptr <= r_ptr + PTR_W'(1);
          if (w_last) r_state <= DONE;
        end
        WB: if (wb_ready_i) begin
          r_dirty[w_ps][w_pw] <= 1'b0;
          if (r_inv) r_valid[w_ps][w_pw] <= 1'b0;
          r_ptr <= r_ptr + PTR_W'(1);
          r_state <= w_last ? DONE : SCAN;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_sram_nway.sv
// tb_dcache_sram_nway: directed scoreboard bench for the 4-way cache array and flush engine.
module tb_dcache_sram_nway;
  localparam int SETS = 16, WAYS = 4, TAG_W = 23, LINE_W = 256, IDX_W = 4, WAY_W = 2;
  localparam int LK = 0, WH = 1, FL = 2;
  logic clk_i = 1'b0;
  logic rst_i, req_i, dirty_i, flush_i, flush_inv_i, wb_ready_i;
  logic [1:0] op_i;
  logic [IDX_W-1:0] idx_i, wb_idx_o;
  logic [TAG_W-1:0] tag_i, victim_tag_o, wb_tag_o;
  logic [LINE_W-1:0] data_i, data_o, wb_data_o;
  logic ready_o, hit_o, victim_valid_o, victim_dirty_o, busy_o, wb_valid_o, flush_done_o;
  logic [WAY_W-1:0] hit_way_o, victim_way_o;
  typedef struct {logic hit; logic [1:0] hw; logic [LINE_W-1:0] d; logic [1:0] vw; logic vv; logic vd; logic [TAG_W-1:0] vt;} exp_t;
  typedef struct {logic [IDX_W-1:0] idx; logic [TAG_W-1:0] tag; logic [LINE_W-1:0] d;} wb_t;
  exp_t sbq[$];
  wb_t wbq[$];
  exp_t me;
  wb_t mw;
  int checks = 0, errors = 0, done_cnt = 0, wb_cnt = 0, scan_cnt = 0, rdy_bad = 0;
  int tg [SETS][WAYS];
  logic held = 1'b0;
  logic [IDX_W+TAG_W+LINE_W-1:0] hold_v;
  logic [LINE_W-1:0] a5 = {32{8'hA5}};

  always #5 clk_i = ~clk_i;

  dcache_sram_nway #(.SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W), .LINE_W(LINE_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .op_i(op_i), .idx_i(idx_i), .tag_i(tag_i),
    .data_i(data_i), .dirty_i(dirty_i), .ready_o(ready_o), .hit_o(hit_o), .hit_way_o(hit_way_o),
    .data_o(data_o), .victim_way_o(victim_way_o), .victim_valid_o(victim_valid_o),
    .victim_dirty_o(victim_dirty_o), .victim_tag_o(victim_tag_o), .flush_i(flush_i),
    .flush_inv_i(flush_inv_i), .busy_o(busy_o), .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_idx_o(wb_idx_o), .wb_tag_o(wb_tag_o), .wb_data_o(wb_data_o), .flush_done_o(flush_done_o));

  function automatic logic [LINE_W-1:0] mk(input int x);
    return {8{32'(x)}};
  endfunction

  function automatic exp_t ex(input int h, input int hw, input logic [LINE_W-1:0] d, input int vw, input int vv, input int vd, input int vt);
    exp_t e;
    e.hit = h[0]; e.hw = 2'(hw); e.d = d; e.vw = 2'(vw); e.vv = vv[0]; e.vd = vd[0]; e.vt = TAG_W'(vt);
    return e;
  endfunction

  function automatic wb_t wbe(input int idx, input int tag);
    wb_t w;
    w.idx = IDX_W'(idx); w.tag = TAG_W'(tag); w.d = mk(tag);
    return w;
  endfunction

  task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic acc(input int op, input int idx, input int tag, input logic [LINE_W-1:0] d, input int dty, input exp_t e);
    sbq.push_back(e);
    req_i = 1'b1; op_i = 2'(op); idx_i = IDX_W'(idx); tag_i = TAG_W'(tag); data_i = d; dirty_i = dty[0];
    @(posedge clk_i); #1 req_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    @(posedge clk_i); #1 rst_i = 1'b0;
    wbq.delete();
  endtask

  task automatic flush(input logic inv);
    flush_i = 1'b1; flush_inv_i = inv;
    @(posedge clk_i); #1 flush_i = 1'b0;
  endtask

  task automatic wait_wb();
    for (int n = 0; n < 200 && !wb_valid_o; n++) @(negedge clk_i);
    chk("wb_valid_timeout", LINE_W'(wb_valid_o), 1);
  endtask

  task automatic wait_done();
    for (int n = 0; n < 500 && !flush_done_o; n++) @(negedge clk_i);
    chk("flush_done_timeout", LINE_W'(flush_done_o), 1);
    @(posedge clk_i); #1;
  endtask

  // Lookup scoreboard: every accepted request is checked against the next queued expectation.
  always @(negedge clk_i) begin
    if (!rst_i && req_i && ready_o) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL lookup_unexpected idx %0d tag %0h", idx_i, tag_i);
      end else begin
        me = sbq.pop_front();
        if ({hit_o, hit_way_o, data_o, victim_way_o, victim_valid_o, victim_dirty_o, victim_tag_o} !==
            {me.hit, me.hw, me.d, me.vw, me.vv, me.vd, me.vt}) begin
          errors++;
          $display("FAIL lookup idx %0d tag %0h got hit %b way %0d vic %0d v%b d%b t%0h data %0h want hit %b way %0d vic %0d v%b d%b t%0h data %0h",
                   idx_i, tag_i, hit_o, hit_way_o, victim_way_o, victim_valid_o, victim_dirty_o, victim_tag_o, data_o,
                   me.hit, me.hw, me.vw, me.vv, me.vd, me.vt, me.d);
        end
      end
    end
  end

  always @(negedge clk_i) begin
    if (wb_valid_o) begin
      if (held) begin
        checks++;
        if ({wb_idx_o, wb_tag_o, wb_data_o} !== hold_v) begin
          errors++;
          $display("FAIL wb_stable got idx %0d tag %0h want idx %0d tag %0h", wb_idx_o, wb_tag_o,
                   hold_v[IDX_W+TAG_W+LINE_W-1 -: IDX_W], hold_v[TAG_W+LINE_W-1 -: TAG_W]);
        end
      end
      held = !wb_ready_i;
      hold_v = {wb_idx_o, wb_tag_o, wb_data_o};
      if (wb_ready_i) begin
        wb_cnt++;
        checks++;
        if (wbq.size() == 0) begin
          errors++;
          $display("FAIL wb_unexpected idx %0d tag %0h", wb_idx_o, wb_tag_o);
        end else begin
          mw = wbq.pop_front();
          if ({wb_idx_o, wb_tag_o, wb_data_o} !== {mw.idx, mw.tag, mw.d}) begin
            errors++;
            $display("FAIL wb_line got idx %0d tag %0h data %0h want idx %0d tag %0h data %0h",
                     wb_idx_o, wb_tag_o, wb_data_o, mw.idx, mw.tag, mw.d);
          end
        end
      end
    end else held = 1'b0;
    if (flush_done_o) done_cnt++;
    if (busy_o && !wb_valid_o && !flush_done_o) scan_cnt++;
    if (busy_o && ready_o) rdy_bad++;
  end

  initial begin
    rst_i = 1'b0; req_i = 1'b0; op_i = '0; idx_i = '0; tag_i = '0; data_i = '0; dirty_i = 1'b0;
    flush_i = 1'b0; flush_inv_i = 1'b0; wb_ready_i = 1'b1;
    @(posedge clk_i); #1;
    do_reset();
    chk("rst_busy", LINE_W'(busy_o), 0);
    chk("rst_ready", LINE_W'(ready_o), 1);
    chk("rst_wb_valid", LINE_W'(wb_valid_o), 0);
    chk("rst_done", LINE_W'(flush_done_o), 0);
    chk("rst_vic", LINE_W'({victim_way_o, victim_valid_o, victim_dirty_o, victim_tag_o}), 0);
    chk("idle_data", data_o, '0);
    // set 3: in-order fills then true-LRU eviction
    acc(FL, 3, 'h10, mk('h10), 0, ex(0, 0, '0, 0, 0, 0, 0));
    acc(FL, 3, 'h11, mk('h11), 0, ex(0, 0, '0, 1, 0, 0, 0));
    acc(FL, 3, 'h12, mk('h12), 0, ex(0, 0, '0, 2, 0, 0, 0));
    acc(FL, 3, 'h13, mk('h13), 0, ex(0, 0, '0, 3, 0, 0, 0));
    acc(LK, 3, 'h10, '0, 0, ex(1, 0, mk('h10), 0, 1, 0, 'h10));
    acc(FL, 3, 'h14, mk('h14), 1, ex(0, 0, mk('h11), 1, 1, 0, 'h11));
    acc(LK, 3, 'h99, '0, 0, ex(0, 0, mk('h12), 2, 1, 0, 'h12));
    acc(LK, 3, 'h12, '0, 0, ex(1, 2, mk('h12), 2, 1, 0, 'h12));
    acc(LK, 3, 'h11, '0, 0, ex(0, 0, mk('h13), 3, 1, 0, 'h13));
    acc(LK, 3, 'h14, '0, 0, ex(1, 1, mk('h14), 3, 1, 0, 'h13));
    acc(3, 3, 'h10, mk('hDEAD), 1, ex(1, 0, mk('h10), 3, 1, 0, 'h13));
    acc(LK, 3, 'h77, '0, 0, ex(0, 0, mk('h13), 3, 1, 0, 'h13));
    acc(LK, 3, 'h10, '0, 0, ex(1, 0, mk('h10), 3, 1, 0, 'h13));
    // set 5: write-hit sets dirty, invalid ways chosen first
    acc(FL, 5, 'h20, mk('h20), 0, ex(0, 0, '0, 0, 0, 0, 0));
    acc(WH, 5, 'h20, a5, 0, ex(1, 0, mk('h20), 1, 0, 0, 0));
    acc(LK, 5, 'h21, '0, 0, ex(0, 0, '0, 1, 0, 0, 0));
    acc(FL, 5, 'h21, mk('h21), 0, ex(0, 0, '0, 1, 0, 0, 0));
    acc(FL, 5, 'h22, mk('h22), 0, ex(0, 0, '0, 2, 0, 0, 0));
    acc(FL, 5, 'h23, mk('h23), 0, ex(0, 0, '0, 3, 0, 0, 0));
    acc(LK, 5, 'h24, '0, 0, ex(0, 0, a5, 0, 1, 1, 'h20));
    // set 2: write-hit to an absent tag changes nothing
    acc(FL, 2, 'h30, mk('h30), 0, ex(0, 0, '0, 0, 0, 0, 0));
    acc(WH, 2, 'h33, mk('hBAD), 0, ex(0, 0, '0, 1, 0, 0, 0));
    acc(LK, 2, 'h30, '0, 0, ex(1, 0, mk('h30), 1, 0, 0, 0));
    acc(LK, 2, 'h33, '0, 0, ex(0, 0, '0, 1, 0, 0, 0));
    // flush without invalidation, back-pressured first write-back
    do_reset();
    idx_i = 4'd3;
    #1 chk("rst_set3_vic", LINE_W'({victim_way_o, victim_valid_o, victim_tag_o}), 0);
    tg[1][0] = 'h40; tg[9][0] = 'h50; tg[9][1] = 'h51;
    acc(FL, 1, 'h40, mk('h40), 1, ex(0, 0, '0, 0, 0, 0, 0));
    acc(FL, 9, 'h50, mk('h50), 0, ex(0, 0, '0, 0, 0, 0, 0));
    acc(FL, 9, 'h51, mk('h51), 1, ex(0, 0, '0, 1, 0, 0, 0));
    wbq.push_back(wbe(1, 'h40));
    wbq.push_back(wbe(9, 'h51));
    wb_ready_i = 1'b0; done_cnt = 0; wb_cnt = 0; scan_cnt = 0;
    flush(1'b0);
    chk("flush1_busy", LINE_W'({busy_o, ready_o}), 2);
    wait_wb();
    chk("flush1_first_idx", LINE_W'(wb_idx_o), 1);
    repeat (3) @(posedge clk_i);
    #1 wb_ready_i = 1'b1;
    wait_done();
    chk("flush1_done_cnt", LINE_W'(done_cnt), 1);
    chk("flush1_wb_cnt", LINE_W'(wb_cnt), 2);
    chk("flush1_wbq_left", LINE_W'(wbq.size()), 0);
    chk("flush1_idle", LINE_W'({busy_o, ready_o, flush_done_o}), 2);
    acc(LK, 1, 'h40, '0, 0, ex(1, 0, mk('h40), 1, 0, 0, 0));
    acc(LK, 9, 'h51, '0, 0, ex(1, 1, mk('h51), 2, 0, 0, 0));
    // fill the rest of the cache, two fresh dirty lines
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++)
        if (!((s == 1 && w == 0) || (s == 9 && w < 2))) begin
          tg[s][w] = 'h200 + s * 4 + w;
          acc(FL, s, tg[s][w], mk(tg[s][w]), int'((s == 0 && w == 3) || (s == 15 && w == 0)), ex(0, 0, '0, w, 0, 0, 0));
        end
    wbq.push_back(wbe(0, tg[0][3]));
    wbq.push_back(wbe(15, tg[15][0]));
    done_cnt = 0; wb_cnt = 0; scan_cnt = 0; rdy_bad = 0;
    flush(1'b1);
    req_i = 1'b1; op_i = 2'd0; idx_i = 4'd1; tag_i = 23'h40;
    repeat (4) begin
      @(negedge clk_i);
      chk("busy_hit_masked", LINE_W'({hit_o, hit_way_o}), 0);
      chk("busy_data_masked", data_o, '0);
    end
    @(posedge clk_i); #1 flush_i = 1'b1; flush_inv_i = 1'b0; req_i = 1'b0;
    @(posedge clk_i); #1 flush_i = 1'b0;
    wait_done();
    chk("flush2_scan_cycles", LINE_W'(scan_cnt), 64);
    chk("flush2_wb_cnt", LINE_W'(wb_cnt), 2);
    chk("flush2_done_cnt", LINE_W'(done_cnt), 1);
    chk("flush2_ready_low", LINE_W'(rdy_bad), 0);
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++)
        acc(LK, s, tg[s][w], '0, 0, ex(0, 0, mk(tg[s][0]), 0, 0, 0, tg[s][0]));
    // reset in the middle of a write-back
    acc(FL, 6, 'h60, mk('h60), 1, ex(0, 0, mk(tg[6][0]), 0, 0, 0, tg[6][0]));
    wbq.push_back(wbe(6, 'h60));
    wb_ready_i = 1'b0; done_cnt = 0;
    flush(1'b0);
    wait_wb();
    @(posedge clk_i); #1;
    do_reset();
    chk("midwb_rst_busy", LINE_W'({busy_o, wb_valid_o}), 0);
    wb_ready_i = 1'b1;
    repeat (70) @(posedge clk_i);
    #1 chk("midwb_no_done", LINE_W'(done_cnt), 0);
    acc(LK, 6, 'h60, '0, 0, ex(0, 0, '0, 0, 0, 0, 0));
    chk("sb_drained", LINE_W'(sbq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
